// File: rtl/compare_cards_n.sv
// Memory-game card comparator for a ROWS x COLS grid with MATCH_N-card sets.
// Picks read card values from an external one-cycle-latency ROM and are checked once a set is complete.
module compare_cards_n #(
    parameter int unsigned  ROWS        = 6,
    parameter int unsigned  COLS        = 6,
    parameter int unsigned  VAL_W       = 5,
    parameter int unsigned  MATCH_N     = 2,
    parameter int unsigned  HOLD_CYCLES = 25_000_000,
    parameter logic [2:0]   PLAY_STATE  = 3'd2,
    localparam int unsigned N           = ROWS * COLS,
    localparam int unsigned IDX_W       = $clog2(N),
    localparam int unsigned CNT_W       = $clog2(N / MATCH_N + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     A,
    input  logic [2:0]               inputState,
    input  logic [IDX_W-1:0]         mem6x6,
    output logic [IDX_W-1:0]         rd_addr,
    input  logic [VAL_W-1:0]         rd_data,
    output logic [MATCH_N*VAL_W-1:0] pick_vals,
    output logic [1:0]               pick_cnt,
    output logic [N-1:0]             face_up,
    output logic [N-1:0]             found,
    output logic [CNT_W-1:0]         pairsFound,
    output logic                     match_pulse,
    output logic                     miss_pulse,
    output logic                     reject_pulse,
    output logic                     busy,
    output logic                     GO
);

    localparam int unsigned SETS   = N / MATCH_N;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_CHECK,
        S_HOLD,
        S_CLEAR,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               a_q;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0]   idx_q  [MATCH_N];
    logic [IDX_W-1:0]   idx_d  [MATCH_N];
    logic [VAL_W-1:0]   vals_q [MATCH_N];
    logic [VAL_W-1:0]   vals_d [MATCH_N];
    logic [1:0]         pick_cnt_q, pick_cnt_d;
    logic [N-1:0]       face_up_q, face_up_d;
    logic [N-1:0]       found_q, found_d;
    logic [CNT_W-1:0]   pairs_q, pairs_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               match_q, match_d;
    logic               miss_q, miss_d;
    logic               reject_q, reject_d;
    logic               busy_q, busy_d;
    logic               go_q, go_d;

    logic               play;
    logic               pick_edge;
    logic               in_range;
    logic               already_found;
    logic               dup;
    logic               all_eq;

    // Pick qualification and set comparison.
    always_comb begin
        play          = (inputState == PLAY_STATE);
        pick_edge     = A & ~a_q;
        in_range      = (32'(mem6x6) < N);
        already_found = in_range && found_q[mem6x6];
        dup           = 1'b0;
        all_eq        = 1'b1;
        for (int k = 0; k < MATCH_N; k++) begin
            if ((2'(k) < pick_cnt_q) && (idx_q[k] == mem6x6)) begin
                dup = 1'b1;
            end
            if (vals_q[k] != vals_q[0]) begin
                all_eq = 1'b0;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        idx_d      = idx_q;
        vals_d     = vals_q;
        pick_cnt_d = pick_cnt_q;
        face_up_d  = face_up_q;
        found_d    = found_q;
        pairs_d    = pairs_q;
        hold_d     = hold_q;
        match_d    = 1'b0;
        miss_d     = 1'b0;
        reject_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_edge && play) begin
                    if (!in_range || already_found || dup) begin
                        reject_d = 1'b1;
                    end else begin
                        cur_idx_d = mem6x6;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                for (int k = 0; k < MATCH_N; k++) begin
                    if (2'(k) == pick_cnt_q) begin
                        vals_d[k] = rd_data;
                        idx_d[k]  = cur_idx_q;
                    end
                end
                face_up_d[cur_idx_q] = 1'b1;
                pick_cnt_d           = pick_cnt_q + 2'd1;
                state_d = (pick_cnt_d == 2'(MATCH_N)) ? S_CHECK : S_IDLE;
            end
            S_CHECK: begin
                if (all_eq) begin
                    for (int k = 0; k < MATCH_N; k++) begin
                        found_d[idx_q[k]]   = 1'b1;
                        face_up_d[idx_q[k]] = 1'b1;
                    end
                    pairs_d    = pairs_q + CNT_W'(1);
                    match_d    = 1'b1;
                    pick_cnt_d = 2'd0;
                    state_d    = (pairs_d == CNT_W'(SETS)) ? S_DONE : S_IDLE;
                end else begin
                    miss_d  = 1'b1;
                    hold_d  = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = S_CLEAR;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_CLEAR: begin
                face_up_d  = found_q;
                pick_cnt_d = 2'd0;
                state_d    = S_IDLE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving play mid-set drops the unmatched picks but keeps progress.
        if (!play && (state_q inside {S_FETCH, S_CAPTURE, S_CHECK, S_HOLD})) begin
            state_d    = S_IDLE;
            idx_d      = idx_q;
            vals_d     = vals_q;
            face_up_d  = found_q;
            found_d    = found_q;
            pairs_d    = pairs_q;
            pick_cnt_d = 2'd0;
            match_d    = 1'b0;
            miss_d     = 1'b0;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        go_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= 1'b0;
            cur_idx_q  <= '0;
            for (int k = 0; k < MATCH_N; k++) begin
                idx_q[k]  <= '0;
                vals_q[k] <= '0;
            end
            pick_cnt_q <= 2'd0;
            face_up_q  <= '0;
            found_q    <= '0;
            pairs_q    <= '0;
            hold_q     <= '0;
            match_q    <= 1'b0;
            miss_q     <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= A;
            cur_idx_q  <= cur_idx_d;
            idx_q      <= idx_d;
            vals_q     <= vals_d;
            pick_cnt_q <= pick_cnt_d;
            face_up_q  <= face_up_d;
            found_q    <= found_d;
            pairs_q    <= pairs_d;
            hold_q     <= hold_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            reject_q   <= reject_d;
            busy_q     <= busy_d;
            go_q       <= go_d;
        end
    end

    always_comb begin
        pick_vals = '0;
        for (int k = 0; k < MATCH_N; k++) begin
            pick_vals[k*VAL_W +: VAL_W] = vals_q[k];
        end
    end

    assign rd_addr      = cur_idx_q;
    assign pick_cnt     = pick_cnt_q;
    assign face_up      = face_up_q;
    assign found        = found_q;
    assign pairsFound   = pairs_q;
    assign match_pulse  = match_q;
    assign miss_pulse   = miss_q;
    assign reject_pulse = reject_q;
    assign busy         = busy_q;
    assign GO           = go_q;

endmodule

// File: tb/tb_compare_cards_n.sv
// Scoreboard bench for compare_cards_n: a pair-matching instance and a triple-matching instance,
// driven with directed scenarios and randomized full games against an event-level game model.
module tb_compare_cards_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        a_i   [2];
    logic [2:0]  st_i  [2];
    logic [5:0]  mem_i [2];

    logic [5:0]  rd_addr2, rd_addr3;
    logic [4:0]  rd_data2, rd_data3;
    logic [9:0]  pick_vals2;
    logic [14:0] pick_vals3;
    logic [1:0]  pick_cnt2, pick_cnt3;
    logic [35:0] face_up2, face_up3, found2, found3;
    logic [4:0]  pf2;
    logic [3:0]  pf3;
    logic        match2, miss2, rej2, busy2, go2;
    logic        match3, miss3, rej3, busy3, go3;

    compare_cards_n #(.MATCH_N(2), .HOLD_CYCLES(4)) dut2 (
        .clock(clk), .reset(rst), .A(a_i[0]), .inputState(st_i[0]), .mem6x6(mem_i[0]),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .pick_vals(pick_vals2), .pick_cnt(pick_cnt2),
        .face_up(face_up2), .found(found2), .pairsFound(pf2), .match_pulse(match2),
        .miss_pulse(miss2), .reject_pulse(rej2), .busy(busy2), .GO(go2)
    );

    compare_cards_n #(.MATCH_N(3), .HOLD_CYCLES(4)) dut3 (
        .clock(clk), .reset(rst), .A(a_i[1]), .inputState(st_i[1]), .mem6x6(mem_i[1]),
        .rd_addr(rd_addr3), .rd_data(rd_data3), .pick_vals(pick_vals3), .pick_cnt(pick_cnt3),
        .face_up(face_up3), .found(found3), .pairsFound(pf3), .match_pulse(match3),
        .miss_pulse(miss3), .reject_pulse(rej3), .busy(busy3), .GO(go3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Deck ROMs with one cycle of read latency.
    always @(posedge clk) begin
        rd_data2 <= 5'(int'(rd_addr2) % 18);
        rd_data3 <= 5'(int'(rd_addr3) % 12);
    end

    logic [35:0] fu_w [2];
    logic [35:0] fd_w [2];
    int          pf_w [2];
    int          pc_w [2];
    int          rda_w[2];
    logic        busy_w[2];
    logic        go_w [2];
    logic [2:0]  pul_w[2];
    int          slot_w[2][3];

    always_comb begin
        fu_w[0] = face_up2;  fu_w[1] = face_up3;
        fd_w[0] = found2;    fd_w[1] = found3;
        pf_w[0] = int'(pf2); pf_w[1] = int'(pf3);
        pc_w[0] = int'(pick_cnt2); pc_w[1] = int'(pick_cnt3);
        rda_w[0] = int'(rd_addr2); rda_w[1] = int'(rd_addr3);
        busy_w[0] = busy2;   busy_w[1] = busy3;
        go_w[0] = go2;       go_w[1] = go3;
        pul_w[0] = {match2, miss2, rej2};
        pul_w[1] = {match3, miss3, rej3};
        slot_w[0][0] = int'(pick_vals2[4:0]);
        slot_w[0][1] = int'(pick_vals2[9:5]);
        slot_w[0][2] = 0;
        slot_w[1][0] = int'(pick_vals3[4:0]);
        slot_w[1][1] = int'(pick_vals3[9:5]);
        slot_w[1][2] = int'(pick_vals3[14:10]);
    end

    // Game model: per instance, found cards, open picks, sets found, game over.
    bit [35:0] found_m [2];
    int        pk      [2][3];
    int        pk_n    [2];
    int        pairs_m [2];
    bit        go_m    [2];

    typedef struct {
        int kind;   // 1 reject, 3 match, 4 miss
        int pairs;
        bit go;
        int cyc;
    } ev_t;
    ev_t q0[$];
    ev_t q1[$];

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int mn(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int val(int d, int i);
        return (d == 0) ? (i % 18) : (i % 12);
    endfunction

    function automatic bit in_pk(int d, int i);
        for (int k = 0; k < pk_n[d]; k++) if (pk[d][k] == i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [35:0] exp_fu(int d);
        logic [35:0] r;
        r = found_m[d];
        for (int k = 0; k < pk_n[d]; k++) r[pk[d][k]] = 1'b1;
        return r;
    endfunction

    // Returns 0 ignored, 1 rejected, 2 accepted (set open), 3 match, 4 miss.
    function automatic int model_pick(int d, int i);
        bit eq;
        if (go_m[d] || st_i[d] != 3'd2) return 0;
        if (i >= 36 || found_m[d][i] || in_pk(d, i)) return 1;
        pk[d][pk_n[d]] = i;
        pk_n[d]++;
        if (pk_n[d] < mn(d)) return 2;
        eq = 1'b1;
        for (int k = 1; k < mn(d); k++) if (val(d, pk[d][k]) != val(d, pk[d][0])) eq = 1'b0;
        pk_n[d] = 0;
        if (!eq) return 4;
        for (int k = 0; k < mn(d); k++) found_m[d][pk[d][k]] = 1'b1;
        pairs_m[d]++;
        if (pairs_m[d] == 36 / mn(d)) go_m[d] = 1'b1;
        return 3;
    endfunction

    function automatic int rand_unfound(int d);
        int j;
        for (int t = 0; t < 200; t++) begin
            j = int'($urandom_range(0, 35));
            if (!found_m[d][j] && !in_pk(d, j)) return j;
        end
        for (int k = 0; k < 36; k++) if (!found_m[d][k] && !in_pk(d, k)) return k;
        return 0;
    endfunction

    function automatic int choose(int d);
        int r;
        int j;
        r = int'($urandom_range(0, 9));
        if (pk_n[d] > 0) begin
            if (r < 6) begin
                for (int k = 0; k < 36; k++)
                    if (!found_m[d][k] && !in_pk(d, k) && val(d, k) == val(d, pk[d][0])) return k;
            end
            if (r == 8) return pk[d][0];
            if (r == 9) return int'($urandom_range(0, 63));
        end else begin
            if (r == 0) return 36 + int'($urandom_range(0, 27));
            if (r == 1 && pairs_m[d] > 0) begin
                for (int t = 0; t < 200; t++) begin
                    j = int'($urandom_range(0, 35));
                    if (found_m[d][j]) return j;
                end
            end
        end
        return rand_unfound(d);
    endfunction

    // Monitor: every pulse is popped against the expected event queue.
    int  mon_k;
    ev_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (pul_w[d] != 3'b000) begin
                    mon_k = (pul_w[d] == 3'b001) ? 1 : (pul_w[d] == 3'b100) ? 3 :
                            (pul_w[d] == 3'b010) ? 4 : 99;
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse dut%0d: got kind %0d at cycle %0d, expected none",
                                 d, mon_k, cyc);
                    end else begin
                        if (d == 0) mon_e = q0.pop_front();
                        else        mon_e = q1.pop_front();
                        chk("pulse_kind", mon_k, mon_e.kind);
                        chk("pulse_cycle", cyc, mon_e.cyc);
                        chk("pulse_pairs", pf_w[d], mon_e.pairs);
                        chk("pulse_go", go_w[d], mon_e.go);
                    end
                end
            end
        end
    end

    task automatic pick(int d, int i, bit settle, int hold);
        int  c;
        int  r;
        int  slot;
        int  n;
        ev_t e;
        @(negedge clk);
        mem_i[d] = 6'(i);
        a_i[d]   = 1'b1;
        c        = cyc;
        slot     = pk_n[d];
        r        = model_pick(d, i);
        if (r == 1 || r == 3 || r == 4) begin
            e.kind  = r;
            e.pairs = pairs_m[d];
            e.go    = go_m[d];
            e.cyc   = (r == 1) ? c + 1 : c + 4;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        repeat (hold) @(negedge clk);
        a_i[d] = 1'b0;
        if (!settle) return;
        n = 0;
        while (busy_w[d] && n < 60) begin
            if (r == 4 && cyc == c + 8) chk("hold_face_up", fu_w[d][i], 1);
            @(negedge clk);
            n++;
        end
        if (busy_w[d]) chk("busy_timeout", 1, 0);
        if (hold == 1 && r == 2) chk("capture_cycle", cyc, c + 3);
        if (hold == 1 && r == 4) chk("clear_cycle", cyc, c + 9);
        if (hold == 1 && r == 1) chk("reject_no_fetch", cyc, c + 1);
        chk("face_up", longint'(fu_w[d]), longint'(exp_fu(d)));
        chk("found", longint'(fd_w[d]), longint'(found_m[d]));
        chk("pick_cnt", pc_w[d], pk_n[d]);
        chk("pairs", pf_w[d], pairs_m[d]);
        chk("go", go_w[d], go_m[d]);
        if (r >= 2) begin
            chk("pick_val", slot_w[d][slot], val(d, i));
            chk("rd_addr", rda_w[d], i);
        end
    endtask

    // Applies one reset cycle starting at the current negedge.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_face_up", longint'(fu_w[d]), 0);
            chk("rst_found", longint'(fd_w[d]), 0);
            chk("rst_pairs", pf_w[d], 0);
            chk("rst_pick_cnt", pc_w[d], 0);
            chk("rst_busy", busy_w[d], 0);
            chk("rst_go", go_w[d], 0);
            chk("rst_pulses", pul_w[d], 0);
            chk("rst_rd_addr", rda_w[d], 0);
            chk("rst_pick_vals", slot_w[d][0] + slot_w[d][1] + slot_w[d][2], 0);
            found_m[d] = '0;
            pk_n[d]    = 0;
            pairs_m[d] = 0;
            go_m[d]    = 1'b0;
        end
        chk("rst_pending_events", q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
        rst = 1'b0;
    endtask

    task automatic full_game(int d);
        for (int it = 0; it < 800 && !go_m[d]; it++) pick(d, choose(d), 1'b1, 1);
        chk("game_go", go_w[d], 1);
        chk("game_sets", pf_w[d], 36 / mn(d));
        for (int k = 0; k < 3; k++) pick(d, int'($urandom_range(0, 35)), 1'b1, 1);
        chk("after_go_busy", busy_w[d], 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            a_i[d]   = 1'b0;
            st_i[d]  = 3'd2;
            mem_i[d] = '0;
        end
        @(negedge clk);
        do_reset();

        // Match, mismatch, found-card reject.
        pick(0, 0, 1'b1, 1);
        pick(0, 18, 1'b1, 1);
        pick(0, 5, 1'b1, 1);
        pick(0, 6, 1'b1, 1);
        pick(0, 0, 1'b1, 1);

        // Reset while fetching.
        pick(0, 1, 1'b0, 1);
        chk("fetch_busy", busy_w[0], 1);
        do_reset();

        // Same card twice, out of range, then complete the set; A held high.
        pick(0, 18, 1'b1, 1);
        pick(0, 18, 1'b1, 1);
        pick(0, 40, 1'b1, 1);
        pick(0, 0, 1'b1, 1);
        pick(0, 7, 1'b1, 10);
        pick(0, 25, 1'b1, 1);

        // Abort while fetching.
        pick(0, 3, 1'b0, 1);
        st_i[0] = 3'd0;
        @(negedge clk);
        pk_n[0] = 0;
        chk("abort_fetch_busy", busy_w[0], 0);
        chk("abort_fetch_face_up", longint'(fu_w[0]), longint'(exp_fu(0)));
        chk("abort_fetch_pick_cnt", pc_w[0], 0);
        repeat (3) @(negedge clk);
        st_i[0] = 3'd2;

        // Abort while holding a mismatch.
        pick(0, 5, 1'b1, 1);
        pick(0, 6, 1'b0, 1);
        repeat (4) @(negedge clk);
        st_i[0] = 3'd0;
        @(negedge clk);
        chk("abort_hold_busy", busy_w[0], 0);
        chk("abort_hold_face_up", longint'(fu_w[0]), longint'(found_m[0]));
        chk("abort_hold_pick_cnt", pc_w[0], 0);
        chk("abort_hold_found", longint'(fd_w[0]), longint'(found_m[0]));
        chk("abort_hold_pairs", pf_w[0], pairs_m[0]);
        repeat (6) @(negedge clk);

        // Edges outside play are ignored.
        pick(0, 9, 1'b1, 1);
        pick(0, 40, 1'b1, 1);
        st_i[0] = 3'd2;

        // Reset while holding a mismatch.
        pick(0, 2, 1'b1, 1);
        pick(0, 4, 1'b0, 1);
        repeat (5) @(negedge clk);
        do_reset();

        full_game(0);
        @(negedge clk);
        do_reset();
        full_game(1);

        repeat (10) @(negedge clk);
        chk("events_drained", q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/compare_cards_n.md
# compare_cards_n

Parametrised successor to the memory-game card comparator. It accepts player card selections on a grid of ROWS×COLS cards and fetches each card value from an external deck ROM with one cycle of read latency. Once MATCH_N cards are picked, it checks them for a match, tracks found cards and face-up cards for the VGA renderer, and holds mismatched cards visible for a programmable time. It sits between the button/cursor logic and the VGA display and game-state controller, and asserts GO when every set has been found.

## Interface
Parameters:
- ROWS, 6, grid rows
- COLS, 6, grid columns; N = ROWS*COLS; N must be divisible by MATCH_N
- VAL_W, 5, card value width
- MATCH_N, 2, cards per set; legal values are 2 or 3
- HOLD_CYCLES, 25_000_000, cycles a mismatched set stays face-up; minimum 1
- PLAY_STATE, 3'd2, inputState value that enables play

Ports (IDX_W = $clog2(N), CNT_W = $clog2(N/MATCH_N+1)):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- A  in  1  select button, debounced level; the rising edge is the pick event
- inputState  in  3  game controller state
- mem6x6  in  IDX_W  index of the card under the cursor
- rd_addr  out  IDX_W  deck ROM address
- rd_data  in  VAL_W  deck ROM data, valid the cycle after rd_addr
- pick_vals  out  MATCH_N*VAL_W  captured values; slot k is at bits [k*VAL_W +: VAL_W]
- pick_cnt  out  2  cards picked in the current set
- face_up  out  N  one bit per card: found, or currently picked
- found  out  N  one bit per card already matched
- pairsFound  out  CNT_W  sets found
- match_pulse, miss_pulse, reject_pulse  out  1  each a one-cycle event
- busy  out  1  high in any state other than IDLE and DONE
- GO  out  1  game over

## Operation
- A is registered into a_q. A pick event is A & ~a_q while state = IDLE and inputState == PLAY_STATE. Edges in any other state are dropped, not queued.
- A pick is rejected when any of these hold:
  - mem6x6 ≥ N;
  - found[mem6x6] is set;
  - mem6x6 equals an index already picked in the current set.
- On a rejected pick: reject_pulse, no state change.
- States:
  - IDLE: on an accepted pick, latch cur_idx <= mem6x6 and go to FETCH.
  - FETCH: rd_addr = cur_idx; go to CAPTURE.
  - CAPTURE: write rd_data into slot pick_cnt, set face_up[cur_idx], record the index, increment pick_cnt. Go to CHECK if the new pick_cnt == MATCH_N, else IDLE.
  - CHECK: if all MATCH_N slots are equal, set found and face_up for the picked indices, increment pairsFound, raise match_pulse, clear pick_cnt. Then go to DONE if pairsFound reaches N/MATCH_N, else IDLE. If the slots differ, raise miss_pulse and go to HOLD.
  - HOLD: count HOLD_CYCLES cycles, then go to CLEAR.
  - CLEAR: clear face_up for the picked indices, clear pick_cnt, go to IDLE.
  - DONE: GO = 1. Exit only on reset.
- rd_addr holds cur_idx in every state; the ROM is read only in FETCH.
- Abort: if inputState != PLAY_STATE in FETCH, CAPTURE, CHECK or HOLD, go to IDLE next cycle.
  - On abort, face_up bits of unmatched picks clear and pick_cnt = 0.
  - found and pairsFound are retained.
  - No match_pulse or miss_pulse is raised.
- pick_vals keep their last contents until overwritten; consumers qualify them with pick_cnt.

## Timing
- Reset values:
  - state = IDLE; all pulses = 0; GO = 0; busy = 0;
  - face_up = 0, found = 0, pairsFound = 0, pick_cnt = 0;
  - pick_vals = 0, rd_addr = 0, a_q = 0.
- Pick edge sampled at cycle t:
  - t+1 FETCH;
  - t+2 CAPTURE;
  - face_up[idx] and pick_vals slot visible at t+3.
- Final pick:
  - CHECK at t+3;
  - match_pulse or miss_pulse, found and pairsFound visible at t+4.
- Mismatch: face_up bits clear HOLD_CYCLES+1 cycles after miss_pulse.
- GO rises in the same cycle as the final match_pulse.
- reject_pulse appears the cycle after the rejected edge.
- Reset mid-HOLD or mid-FETCH returns every output to its reset value the next cycle.
- Holding A high produces exactly one pick.

## Test plan
All scenarios use ROWS=COLS=6, VAL_W=5, HOLD_CYCLES=4, and a ROM model returning idx%18 (idx%12 for MATCH_N=3).
- Match: picks 0 then 18, inputState=2 → match_pulse, found[0] and found[18] = 1, pairsFound = 1, face_up bits stay set.
- Mismatch: picks 5 then 6 → miss_pulse at t+4; face_up[5] and face_up[6] clear 5 cycles later; pairsFound unchanged.
- Same card and found card:
  - picks 18 then 18 → second pick gives reject_pulse, pick_cnt stays 1;
  - picking 0 after it is found → reject_pulse.
- Out of range: mem6x6 = 40 → reject_pulse, no FETCH.
- Abort and gating:
  - inputState drops to 0 during HOLD → IDLE next cycle, picks cleared, found retained, no further pulses;
  - edges while inputState != 2 → ignored.
- Full game:
  - MATCH_N=2: play all 18 pairs → GO high with the 18th match_pulse; later edges ignored until reset.
  - MATCH_N=3: play all 12 triples → GO high with the 12th match_pulse.
